turn_sequencer: RTL
===================

// Module: turn_sequencer
// PURPOSE
//  Game-phase controller sequencing one throw per turn: waits for both players ready, runs local
//  aiming (power charge on mouse left), issues throw_flag, waits for particle landing, then
//  resolves HP, advances turn and detects game over. Sits between MouseCtl/choose_player and
//  throw/set_speed/simulate; its turn/power/throw_flag outputs replace throw+turn_manager sequencing.
// PARAMETERS
//  FRAMES_PER_STEP  4    frame_ticks per +1 power step while left held
//  POWER_MAX        15   power saturation value (4-bit)
//  AIM_TIMEOUT      600  frames in local AIM before forced throw (10 s @ 60 Hz)
//  FLIGHT_TIMEOUT   300  frames in FLIGHT without end_throw before forced settle
//  SETTLE_FRAMES    30   frames to show impact before next turn
// PORTS
//  clk60MHz       in   1  system clock
//  rst            in   1  reset, asynchronous, active-high
//  players_ready  in   1  both players ready (level)
//  current_player in   1  player owned by this board (0=cat/player1, 1=dog/player2)
//  left           in   1  mouse left button level (MouseCtl, clk60MHz domain)
//  in_throw_flag  in   1  remote board throw pulse (synchronised upstream)
//  end_throw      in   1  particle landed, 1-cycle pulse
//  frame_tick     in   1  1-cycle pulse per VGA frame
//  hp_player1     in   7  player1 HP
//  hp_player2     in   7  player2 HP
//  throw_flag     out  1  local throw, 1-cycle pulse
//  power          out  4  current aim power
//  turn           out  3  turn counter; turn[0] = active player
//  state          out  3  encoded seq_state_t
//  game_over      out  1  sticky until rst
//  winner         out  1  valid when game_over
// BEHAVIOUR
//  Reset: state=WAIT_READY, power=0, turn=0, throw_flag=0, game_over=0, winner=0, timer=0.
//  All outputs registered; 1-cycle latency from input to output.
//  local = (turn[0]==current_player). Timer counts frame_tick, cleared on every state entry.
//  WAIT_READY: players_ready=1 -> local ? AIM_LOCAL : AIM_REMOTE (next cycle).
//  AIM_LOCAL: left held: power += 1 every FRAMES_PER_STEP ticks, saturate at POWER_MAX.
//   - left 1->0 with power>0: throw_flag pulse, -> FLIGHT; power held through FLIGHT.
//   - left 1->0 with power=0: no throw, stay.
//   - timer==AIM_TIMEOUT: throw with max(power,1), -> FLIGHT.
//   - in_throw_flag ignored. Release and frame_tick same cycle: release wins, no extra step.
//  AIM_REMOTE: in_throw_flag -> FLIGHT. left ignored, power forced 0. No timeout.
//  FLIGHT: end_throw or timer==FLIGHT_TIMEOUT -> SETTLE.
//  SETTLE: after SETTLE_FRAMES ticks sample HP:
//   - hp1==0 && hp2==0 -> GAME_OVER, winner=turn[0] (thrower wins).
//   - hp1==0 -> GAME_OVER, winner=1; hp2==0 -> GAME_OVER, winner=0.
//   - else turn+=1 (7 wraps to 0), power=0, -> AIM_LOCAL/AIM_REMOTE per new turn[0].
//  GAME_OVER: sticky, game_over=1, ignores all inputs until rst.
//  end_throw outside FLIGHT and in_throw_flag outside AIM_REMOTE ignored.
//  players_ready drop in any state except GAME_OVER -> WAIT_READY, power=0, turn kept;
//   drop during FLIGHT abandons the throw (no turn advance).
//  throw_flag never asserted two cycles in a row; at most one per turn.
// STRUCTURE
//  game_pkg: typedef enum logic[2:0] seq_state_t {WAIT_READY,AIM_LOCAL,AIM_REMOTE,FLIGHT,
//   SETTLE,GAME_OVER}; localparams POWER_W=4, HP_W=7, TURN_W=3.
//  Sub-module seq_frame_timer: frame_tick counter with clear and count output, shared by all
//   state timeouts. FSM + power accumulator in turn_sequencer.
// TESTING
//  1 ready=1, turn=0, current_player=0, left held 24 ticks, release -> power=6, one throw_flag, FLIGHT.
//  2 left held 100 ticks -> power saturates 15; release -> throw_flag once, power stays 15 in FLIGHT.
//  3 current_player=1, turn=0: left pulses ignored; in_throw_flag -> FLIGHT; end_throw ->
//    SETTLE; after 30 ticks turn=1, state=AIM_LOCAL.
//  4 AIM_LOCAL untouched 600 ticks -> throw_flag with power=1; no end_throw 300 ticks -> SETTLE.
//  5 SETTLE with hp2=0 -> game_over=1, winner=0, later inputs ignored; both 0 at turn=3 -> winner=1.
//  6 ready drop in FLIGHT -> WAIT_READY, turn unchanged; async rst mid-AIM -> all reset values.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared state encoding and widths for the turn sequencer.
package game_pkg;
  typedef enum logic [2:0] {
    WAIT_READY,
    AIM_LOCAL,
    AIM_REMOTE,
    FLIGHT,
    SETTLE,
    GAME_OVER
  } seq_state_t;
  localparam int POWER_W = 4;
  localparam int HP_W = 7;
  localparam int TURN_W = 3;
  localparam int TIMER_W = 10;
endpackage

// File: rtl/turn_sequencer_if.sv
// turn_sequencer_if: game-phase inputs and sequencing outputs of the turn sequencer.
interface turn_sequencer_if;
  import game_pkg::*;
  logic players_ready;
  logic current_player;
  logic left;
  logic in_throw_flag;
  logic end_throw;
  logic frame_tick;
  logic [HP_W-1:0] hp_player1;
  logic [HP_W-1:0] hp_player2;
  logic throw_flag;
  logic [POWER_W-1:0] power;
  logic [TURN_W-1:0] turn;
  logic [2:0] state;
  logic game_over;
  logic winner;
  modport master (
    output players_ready, current_player, left, in_throw_flag, end_throw, frame_tick,
           hp_player1, hp_player2,
    input  throw_flag, power, turn, state, game_over, winner
  );
  modport slave (
    input  players_ready, current_player, left, in_throw_flag, end_throw, frame_tick,
           hp_player1, hp_player2,
    output throw_flag, power, turn, state, game_over, winner
  );
endinterface

// File: rtl/seq_frame_timer.sv
// seq_frame_timer: saturating frame_tick counter with synchronous clear (clear beats tick).
module seq_frame_timer
  import game_pkg::*;
(
  input  logic               clk60MHz,
  input  logic               rst,
  input  logic               clr,
  input  logic               tick,
  output logic [TIMER_W-1:0] count
);
  logic [TIMER_W-1:0] count_q, count_d;
  always_comb count_d = clr ? '0 : (tick && count_q != '1) ? count_q + 1'b1 : count_q;
  always_ff @(posedge clk60MHz or posedge rst)
    if (rst) count_q <= '0;
    else count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/turn_sequencer.sv
// turn_sequencer: one-throw-per-turn game FSM with power accumulator, settle and game-over detection.
module turn_sequencer
  import game_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 4,
  parameter int POWER_MAX = 15,
  parameter int AIM_TIMEOUT = 600,
  parameter int FLIGHT_TIMEOUT = 300,
  parameter int SETTLE_FRAMES = 30
) (
  input logic             clk60MHz,
  input logic             rst,
  turn_sequencer_if.slave bus
);
  localparam logic [3:0] STEP_LAST = 4'(FRAMES_PER_STEP - 1);
  localparam logic [POWER_W-1:0] PMAX = POWER_W'(POWER_MAX);
  localparam logic [TIMER_W-1:0] AIM_T = TIMER_W'(AIM_TIMEOUT);
  localparam logic [TIMER_W-1:0] FLIGHT_T = TIMER_W'(FLIGHT_TIMEOUT);
  localparam logic [TIMER_W-1:0] SETTLE_T = TIMER_W'(SETTLE_FRAMES);
  seq_state_t state_q, state_d;
  logic [POWER_W-1:0] power_q, power_d;
  logic [TURN_W-1:0] turn_q, turn_d;
  logic [3:0] step_q, step_d;
  logic left_q, throw_flag_q, throw_flag_d, game_over_q, game_over_d, winner_q, winner_d;
  logic is_local, rel, hp1_dead, hp2_dead;
  logic [TIMER_W-1:0] timer;
  seq_frame_timer u_timer (
    .clk60MHz(clk60MHz),
    .rst(rst),
    .clr(state_d != state_q),
    .tick(bus.frame_tick),
    .count(timer)
  );
  assign is_local = turn_q[0] == bus.current_player;
  assign rel = left_q & ~bus.left;
  assign hp1_dead = bus.hp_player1 == '0;
  assign hp2_dead = bus.hp_player2 == '0;
  always_comb begin
    state_d = state_q;
    power_d = power_q;
    turn_d = turn_q;
    step_d = '0;
    throw_flag_d = 1'b0;
    game_over_d = game_over_q;
    winner_d = winner_q;
    case (state_q)
      WAIT_READY: begin
        power_d = '0;
        if (bus.players_ready) state_d = is_local ? AIM_LOCAL : AIM_REMOTE;
      end
      AIM_LOCAL: begin
        // release uses the current left level, so a same-cycle tick never adds a step
        if ((rel && power_q != '0) || timer == AIM_T) begin
          throw_flag_d = 1'b1;
          state_d = FLIGHT;
          power_d = (power_q == '0) ? POWER_W'(1) : power_q;
        end else if (bus.left) begin
          step_d = !bus.frame_tick ? step_q : (step_q == STEP_LAST) ? '0 : step_q + 1'b1;
          power_d = (bus.frame_tick && step_q == STEP_LAST && power_q != PMAX) ? power_q + 1'b1 : power_q;
        end
      end
      AIM_REMOTE: begin
        power_d = '0;
        if (bus.in_throw_flag) state_d = FLIGHT;
      end
      FLIGHT: if (bus.end_throw || timer == FLIGHT_T) state_d = SETTLE;
      SETTLE: begin
        if (timer == SETTLE_T) begin
          if (hp1_dead || hp2_dead) begin
            state_d = GAME_OVER;
            game_over_d = 1'b1;
            winner_d = (hp1_dead && hp2_dead) ? turn_q[0] : hp1_dead;
          end else begin
            turn_d = turn_q + 1'b1;
            power_d = '0;
            state_d = (~turn_q[0] == bus.current_player) ? AIM_LOCAL : AIM_REMOTE;
          end
        end
      end
      GAME_OVER: game_over_d = 1'b1;
      default: state_d = WAIT_READY;
    endcase
    // losing readiness abandons whatever is in progress but keeps the turn
    if (!bus.players_ready && state_q != GAME_OVER) begin
      state_d = WAIT_READY;
      power_d = '0;
      turn_d = turn_q;
      step_d = '0;
      throw_flag_d = 1'b0;
      game_over_d = game_over_q;
      winner_d = winner_q;
    end
  end
  always_ff @(posedge clk60MHz or posedge rst)
    if (rst) begin
      state_q <= WAIT_READY;
      power_q <= '0;
      turn_q <= '0;
      step_q <= '0;
      left_q <= 1'b0;
      throw_flag_q <= 1'b0;
      game_over_q <= 1'b0;
      winner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      power_q <= power_d;
      turn_q <= turn_d;
      step_q <= step_d;
      left_q <= bus.left;
      throw_flag_q <= throw_flag_d;
      game_over_q <= game_over_d;
      winner_q <= winner_d;
    end
  assign bus.throw_flag = throw_flag_q;
  assign bus.power = power_q;
  assign bus.turn = turn_q;
  assign bus.state = state_q;
  assign bus.game_over = game_over_q;
  assign bus.winner = winner_q;
endmodule
